qos_flow_ctrl_fsm: RTL and testbench

Parametrised flow-control state machine for the QoS module. It watches NUM_CH ingress FIFOs through their empty/full flags and occupancy counts. Per channel, it raises pause and continue strobes using programmable hysteresis thresholds, and it reports overflow errors. It sits between the per-VC FIFOs and the link-side pause/continue message generator.

---
 rtl/qos_flow_ctrl_fsm.sv | 85 ++++++++
 tb/tb_qos_flow_ctrl_fsm.sv | 132 +++++++++++++
 2 files changed

// File: rtl/qos_flow_ctrl_fsm.sv
// qos_flow_ctrl_fsm: per-channel pause/continue hysteresis FSM with overflow error tracking
// Optional: define QOS_FSM_ERR_AUTOCLR_EN so ERROR clears itself once no FIFO is full
module qos_flow_ctrl_fsm #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    set_init,
  input  logic [CNT_W-1:0]        pause_th,
  input  logic [CNT_W-1:0]        continue_th,
  input  logic [NUM_CH-1:0]       empty,
  input  logic [NUM_CH-1:0]       full,
  input  logic [NUM_CH*CNT_W-1:0] occ,
  output logic                    init,
  output logic                    idle,
  output logic                    active,
  output logic                    error,
  output logic [NUM_CH-1:0]       pause_stb,
  output logic [NUM_CH-1:0]       continue_stb,
  output logic [NUM_CH-1:0]       error_full
);
  typedef enum logic [2:0] {RESET, INIT, IDLE, ACTIVE, ERROR} state_t;
`ifdef QOS_FSM_ERR_AUTOCLR_EN
  localparam bit autoclr = 1'b1;
`else
  localparam bit autoclr = 1'b0;
`endif
  state_t state, state_n;
  logic [CNT_W-1:0] pause_th_q, continue_th_q, pause_th_n, continue_th_n;
  logic [NUM_CH-1:0] paused, paused_n, pause_hit, cont_hit, pause_stb_n, continue_stb_n, error_full_n;
  logic any_full, eval, load, err_clr;
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= RESET;
      pause_th_q    <= '0;
      continue_th_q <= '0;
      paused        <= '0;
      pause_stb     <= '0;
      continue_stb  <= '0;
      error_full    <= '0;
    end else begin
      state         <= state_n;
      pause_th_q    <= pause_th_n;
      continue_th_q <= continue_th_n;
      paused        <= paused_n;
      pause_stb     <= pause_stb_n;
      continue_stb  <= continue_stb_n;
      error_full    <= error_full_n;
    end
  end
  always_comb begin
    any_full = |full;
    err_clr  = autoclr && !any_full;
    case (state)
      RESET:   state_n = INIT;
      INIT:    state_n = set_init ? INIT : IDLE;
      IDLE:    state_n = set_init ? INIT : any_full ? ERROR : !(&empty) ? ACTIVE : IDLE;
      ACTIVE:  state_n = set_init ? INIT : any_full ? ERROR : (&empty && !(|paused)) ? IDLE : ACTIVE;
      ERROR:   state_n = set_init ? INIT : err_clr ? ACTIVE : ERROR;
      default: state_n = RESET;
    endcase
  end
  // paused gates the two hits, so pause and continue can never fire on one channel together
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pause_hit[i] = !paused[i] && occ[i*CNT_W +: CNT_W] >= pause_th_q;
      cont_hit[i]  = paused[i] && occ[i*CNT_W +: CNT_W] <= continue_th_q;
    end
    eval           = state == ACTIVE && !set_init && !any_full;
    load           = state == INIT && set_init;
    pause_stb_n    = eval ? pause_hit : '0;
    continue_stb_n = eval ? cont_hit : '0;
    paused_n       = state == INIT ? '0 : paused ^ pause_stb_n ^ continue_stb_n;
    pause_th_n     = load ? pause_th : pause_th_q;
    continue_th_n  = load ? continue_th : continue_th_q;
    error_full_n   = (state == IDLE || state == ACTIVE) && !set_init && any_full ? full
                   : state == ERROR ? ((set_init || err_clr) ? '0 : error_full | full)
                   : error_full;
  end
  assign init   = state == INIT;
  assign idle   = state == IDLE;
  assign active = state == ACTIVE;
  assign error  = state == ERROR;
endmodule

// File: tb/tb_qos_flow_ctrl_fsm.sv
// tb_qos_flow_ctrl_fsm: directed scenario checks for qos_flow_ctrl_fsm
module tb_qos_flow_ctrl_fsm;
  logic CLK = 1'b0, reset = 1'b0, set_init = 1'b1;
  logic [3:0] pause_th = 4'd12, continue_th = 4'd4, empty = 4'hF, full = 4'h0;
  logic [15:0] occ = 16'h0;
  logic init, idle, active, error;
  logic [3:0] pause_stb, continue_stb, error_full, st;
  int checks = 0, errors = 0;
  qos_flow_ctrl_fsm #(.NUM_CH(4), .CNT_W(4)) dut (
    .CLK(CLK), .reset(reset), .set_init(set_init), .pause_th(pause_th), .continue_th(continue_th),
    .empty(empty), .full(full), .occ(occ), .init(init), .idle(idle), .active(active), .error(error),
    .pause_stb(pause_stb), .continue_stb(continue_stb), .error_full(error_full)
  );
  assign st = {init, idle, active, error};
  always #5 CLK = ~CLK;
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if ({st, pause_stb, continue_stb, error_full} !== 16'h0) begin errors++; $display("FAIL reset_outs: got %h exp 0000", {st, pause_stb, continue_stb, error_full}); end
    reset = 1'b0;
    step;
    checks++; if ({st, pause_stb, continue_stb, error_full} !== 16'h8000) begin errors++; $display("FAIL reset_to_init: got %h exp 8000", {st, pause_stb, continue_stb, error_full}); end
    step;
    checks++; if (st !== 4'b1000) begin errors++; $display("FAIL init_hold: got %b exp 1000", st); end
    set_init = 1'b0;
    step;
    checks++; if (st !== 4'b0100) begin errors++; $display("FAIL init_to_idle: got %b exp 0100", st); end
  endtask
  task automatic test_pause_continue;
    empty = 4'b1011;
    step;
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL idle_to_active: got %b exp 0010", st); end
    for (int v = 0; v <= 13; v++) begin
      occ[11:8] = v[3:0];
      step;
      checks++; if (pause_stb !== (v == 12 ? 4'b0100 : 4'b0000) || continue_stb !== 4'b0000) begin errors++; $display("FAIL ramp_up occ2=%0d: pause=%b cont=%b", v, pause_stb, continue_stb); end
    end
    for (int v = 11; v >= 4; v--) begin
      occ[11:8] = v[3:0];
      step;
      checks++; if (continue_stb !== (v == 4 ? 4'b0100 : 4'b0000) || pause_stb !== 4'b0000) begin errors++; $display("FAIL ramp_down occ2=%0d: pause=%b cont=%b", v, pause_stb, continue_stb); end
    end
    occ = 16'h0;
    step;
    checks++; if ({pause_stb, continue_stb} !== 8'h00) begin errors++; $display("FAIL after_continue: got %h exp 00", {pause_stb, continue_stb}); end
  endtask
  task automatic test_simultaneous;
    occ = 16'hC00C;
    step;
    checks++; if ({pause_stb, continue_stb} !== 8'h90) begin errors++; $display("FAIL simul_pause: got %h exp 90", {pause_stb, continue_stb}); end
    step;
    checks++; if ({pause_stb, continue_stb} !== 8'h00) begin errors++; $display("FAIL simul_norepeat: got %h exp 00", {pause_stb, continue_stb}); end
    occ = 16'hCC04;
    step;
    checks++; if ({pause_stb, continue_stb} !== 8'h41) begin errors++; $display("FAIL mixed_strobes: got %h exp 41", {pause_stb, continue_stb}); end
    occ = 16'h0;
    step;
    checks++; if ({pause_stb, continue_stb} !== 8'h0C) begin errors++; $display("FAIL simul_continue: got %h exp 0c", {pause_stb, continue_stb}); end
    step;
    checks++; if ({pause_stb, continue_stb} !== 8'h00) begin errors++; $display("FAIL simul_quiet: got %h exp 00", {pause_stb, continue_stb}); end
  endtask
  task automatic test_idle_return;
    occ = 16'h000C;
    step;
    checks++; if (pause_stb !== 4'b0001) begin errors++; $display("FAIL ch0_pause: got %b exp 0001", pause_stb); end
    empty = 4'hF;
    step;
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL paused_stays_active: got %b exp 0010", st); end
    step;
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL paused_stays_active2: got %b exp 0010", st); end
    occ = 16'h0;
    step;
    checks++; if (continue_stb !== 4'b0001 || st !== 4'b0010) begin errors++; $display("FAIL ch0_continue: cont=%b st=%b", continue_stb, st); end
    step;
    checks++; if (st !== 4'b0100) begin errors++; $display("FAIL return_idle: got %b exp 0100", st); end
  endtask
  task automatic test_overflow;
    empty = 4'b1101;
    step;
    checks++; if (st !== 4'b0010) begin errors++; $display("FAIL ovf_active: got %b exp 0010", st); end
    occ = 16'h00C0;
    full = 4'b0010;
    step;
    checks++; if (st !== 4'b0001 || error_full !== 4'b0010 || pause_stb !== 4'b0000) begin errors++; $display("FAIL ovf_enter: st=%b ef=%b pause=%b", st, error_full, pause_stb); end
    full = 4'b1000;
    step;
    checks++; if (st !== 4'b0001 || error_full !== 4'b1010 || pause_stb !== 4'b0000) begin errors++; $display("FAIL ovf_accum: st=%b ef=%b pause=%b", st, error_full, pause_stb); end
    full = 4'b0000;
    step;
`ifdef QOS_FSM_ERR_AUTOCLR_EN
    checks++; if (st !== 4'b0010 || error_full !== 4'b0000) begin errors++; $display("FAIL ovf_autoclr: st=%b ef=%b exp 0010/0000", st, error_full); end
`else
    checks++; if (st !== 4'b0001 || error_full !== 4'b1010) begin errors++; $display("FAIL ovf_sticky: st=%b ef=%b exp 0001/1010", st, error_full); end
`endif
    occ = 16'h0;
    set_init = 1'b1;
    step;
    checks++; if (st !== 4'b1000 || error_full !== 4'b0000) begin errors++; $display("FAIL ovf_to_init: st=%b ef=%b exp 1000/0000", st, error_full); end
    set_init = 1'b0;
    empty = 4'hF;
    step;
    checks++; if (st !== 4'b0100) begin errors++; $display("FAIL ovf_reidle: got %b exp 0100", st); end
  endtask
  task automatic test_async_reset;
    empty = 4'b1110;
    step;
    occ = 16'h000C;
    step;
    checks++; if (pause_stb !== 4'b0001) begin errors++; $display("FAIL pre_reset_pause: got %b exp 0001", pause_stb); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({st, pause_stb, continue_stb, error_full} !== 16'h0) begin errors++; $display("FAIL async_outs: got %h exp 0000", {st, pause_stb, continue_stb, error_full}); end
    checks++; if ({dut.paused, dut.pause_th_q, dut.continue_th_q} !== 12'h0) begin errors++; $display("FAIL async_state: got %h exp 000", {dut.paused, dut.pause_th_q, dut.continue_th_q}); end
    step;
    reset = 1'b0;
  endtask
  initial begin
    test_reset;
    test_pause_continue;
    test_simultaneous;
    test_idle_return;
    test_overflow;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
